// File: rtl/instr_mem_loader_if.sv
// Byte-stream loader bus: host-side start/count and program bytes in,
// instruction-memory write port and load status out.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              Start;
    logic [ADDR_W:0]   Count;
    logic [7:0]        ByteIn;
    logic              ByteValid;
    logic              ByteReady;
    logic              MemWrite;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemData;
    logic              Busy;
    logic              Done;
    logic              UnsupOp;
    logic [ADDR_W-1:0] UnsupAddr;

    // Host / byte source side.
    modport master (
        output Start,
        output Count,
        output ByteIn,
        output ByteValid,
        input  ByteReady,
        input  MemWrite,
        input  MemAddr,
        input  MemData,
        input  Busy,
        input  Done,
        input  UnsupOp,
        input  UnsupAddr
    );

    // Loader side.
    modport slave (
        input  Start,
        input  Count,
        input  ByteIn,
        input  ByteValid,
        output ByteReady,
        output MemWrite,
        output MemAddr,
        output MemData,
        output Busy,
        output Done,
        output UnsupOp,
        output UnsupAddr
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: assembles big-endian 32-bit words from a byte
// stream, writes them to consecutive word addresses starting at 0, and flags
// the first word whose opcode the datapath controller cannot execute.
module instr_mem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                Clk,
    input  logic                Rst,
    instr_mem_loader_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest loadable word count: the whole memory.
    localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;          // words to load, clamped
    logic [ADDR_W:0]   widx_q, widx_d;        // one bit wider so it never wraps
    logic [1:0]        bidx_q, bidx_d;        // byte position inside the word
    logic [31:0]       asm_q, asm_d;          // word under assembly
    logic [31:0]       mem_data_q, mem_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              unsup_q, unsup_d;
    logic [ADDR_W-1:0] unsup_addr_q, unsup_addr_d;

    logic              byte_ready;
    logic              mem_write;
    logic              busy;
    logic              done;

    // Opcodes (instr[31:26]) the datapath controller implements.
    function automatic logic opcode_supported(input logic [5:0] op);
        case (op)
            6'b000000, 6'b001000, 6'b001001, 6'b001010,
            6'b001011, 6'b001100, 6'b001101, 6'b001110,
            6'b011100, 6'b011111, 6'b100000, 6'b100001,
            6'b100011, 6'b101000, 6'b101001, 6'b101011: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    // A request larger than the memory loads the whole memory and stops.
    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
        return (c > MAX_CNT) ? MAX_CNT : c;
    endfunction

    // State and datapath registers; reset returns everything to a clean idle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            widx_q       <= '0;
            bidx_q       <= '0;
            asm_q        <= '0;
            mem_data_q   <= '0;
            mem_addr_q   <= '0;
            unsup_q      <= 1'b0;
            unsup_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            widx_q       <= widx_d;
            bidx_q       <= bidx_d;
            asm_q        <= asm_d;
            mem_data_q   <= mem_data_d;
            mem_addr_q   <= mem_addr_d;
            unsup_q      <= unsup_d;
            unsup_addr_q <= unsup_addr_d;
        end
    end

    // Next-state, byte assembly, write and opcode-check decisions.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        widx_d       = widx_q;
        bidx_d       = bidx_q;
        asm_d        = asm_q;
        mem_data_d   = mem_data_q;
        mem_addr_d   = mem_addr_q;
        unsup_d      = unsup_q;
        unsup_addr_d = unsup_addr_q;
        byte_ready   = 1'b0;
        mem_write    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    if (bus.Count != '0) begin
                        cnt_d        = clamp_count(bus.Count);
                        widx_d       = '0;
                        bidx_d       = '0;
                        unsup_d      = 1'b0;
                        unsup_addr_d = '0;
                        state_d      = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (bus.ByteValid) begin
                    case (bidx_q)
                        2'd0:    asm_d[31:24] = bus.ByteIn;
                        2'd1:    asm_d[23:16] = bus.ByteIn;
                        2'd2:    asm_d[15:8]  = bus.ByteIn;
                        default: asm_d[7:0]   = bus.ByteIn;
                    endcase
                    bidx_d = bidx_q + 2'd1;
                    // Last byte: present the finished word on the write port.
                    if (bidx_q == 2'd3) begin
                        mem_data_d = asm_d;
                        mem_addr_d = widx_q[ADDR_W-1:0];
                        state_d    = WRITE;
                    end
                end
            end

            WRITE: begin
                mem_write = 1'b1;
                busy      = 1'b1;
                // Only the first offending word is recorded; loading goes on.
                if (!opcode_supported(mem_data_q[31:26]) && !unsup_q) begin
                    unsup_d      = 1'b1;
                    unsup_addr_d = mem_addr_q;
                end
                widx_d = widx_q + (ADDR_W+1)'(1);
                if (widx_d == cnt_q) begin
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held.
    assign bus.ByteReady = byte_ready & ~Rst;
    assign bus.MemWrite  = mem_write  & ~Rst;
    assign bus.Busy      = busy       & ~Rst;
    assign bus.Done      = done       & ~Rst;
    assign bus.MemAddr   = Rst ? '0 : mem_addr_q;
    assign bus.MemData   = Rst ? '0 : mem_data_q;
    assign bus.UnsupOp   = unsup_q & ~Rst;
    assign bus.UnsupAddr = Rst ? '0 : unsup_addr_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: table of load scenarios plus hand-written
// reset, zero-count, start-while-busy and full-memory sequences. Expected
// memory writes go into a scoreboard queue and are matched as they appear.
module tb_instr_mem_loader;

    localparam int ADDR_W = 10;

    logic Clk = 1'b0;
    logic Rst;

    instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [10:0]       count;
        int                gap;
        int                poke;     // byte number at which Start is pulsed, -1 none
        logic [3:0][31:0]  w;
        logic              unsup;
        logic [9:0]        uaddr;
    } vec_t;

    wr_t         exp_q[$];
    logic [31:0] word_buf [1024];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    int          n_done   = 0;
    int          busy_err = 0;
    bit          track_busy = 1'b0;
    logic [9:0]  last_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor / scoreboard, Done counter and Busy watcher.
    always @(negedge Clk) begin
        if (bus.MemWrite === 1'b1) begin
            wr_t e;
            n_writes++;
            last_addr = bus.MemAddr;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         bus.MemAddr, bus.MemData);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.MemAddr), 32'(e.addr));
                check("wr_data", bus.MemData, e.data);
            end
        end
        if (bus.Done === 1'b1) n_done++;
        if (track_busy) begin
            if (bus.Done === 1'b1) track_busy = 1'b0;
            else if (bus.Busy !== 1'b1) busy_err++;
        end
    end

    task automatic idle_cycle();
        bus.ByteValid = 1'b0;
        bus.ByteIn    = 8'($urandom);
        @(negedge Clk);
        #1;
    endtask

    task automatic start_pulse(input logic [10:0] count);
        bus.Start = 1'b1;
        bus.Count = count;
        @(negedge Clk);
        #1;
        bus.Start = 1'b0;
        bus.Count = 11'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   t = 0;
        logic rdy;
        logic acc = 1'b0;
        bus.ByteIn    = b;
        bus.ByteValid = 1'b1;
        while (!acc && t < 50) begin
            rdy = bus.ByteReady;
            @(negedge Clk);
            #1;
            acc = rdy;
            t++;
        end
        bus.ByteValid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_accept_timeout: got no ByteReady, expected byte 0x%0h accepted", b);
        end
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (n_done == d0 && t < 40) begin
            @(negedge Clk);
            #1;
            t++;
        end
        if (n_done == d0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no Done pulse, expected one");
        end
    endtask

    // Full load of word_buf[0..min(count,1024)-1] with random gaps up to gap.
    task automatic run_load(input logic [10:0] count, input int gap, input int poke,
                            input logic exp_unsup, input logic [9:0] exp_uaddr);
        int nw = (count > 11'd1024) ? 1024 : int'(count);
        int d0 = n_done;
        int w0 = n_writes;
        for (int i = 0; i < nw; i++) exp_q.push_back({10'(i), word_buf[i]});
        busy_err = 0;
        start_pulse(count);
        track_busy = 1'b1;
        for (int i = 0; i < nw; i++) begin
            for (int b = 0; b < 4; b++) begin
                repeat ($urandom_range(gap, 0)) idle_cycle();
                if (i * 4 + b == poke) start_pulse(11'd7);
                send_byte(word_buf[i][31 - 8*b -: 8]);
            end
        end
        wait_done(d0);
        track_busy = 1'b0;
        repeat (3) idle_cycle();
        check("done_pulses", 32'(n_done - d0), 32'd1);
        check("write_count", 32'(n_writes - w0), 32'(nw));
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("busy_gaps", 32'(busy_err), 32'd0);
        check("busy_idle", 32'(bus.Busy), 32'd0);
        check("unsup_op", 32'(bus.UnsupOp), 32'(exp_unsup));
        check("unsup_addr", 32'(bus.UnsupAddr), 32'(exp_uaddr));
        exp_q.delete();
    endtask

    function automatic vec_t mk(input logic [10:0] count, input int gap, input int poke,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input logic unsup, input logic [9:0] uaddr);
        vec_t v;
        v.count = count;
        v.gap   = gap;
        v.poke  = poke;
        v.w[0]  = w0;
        v.w[1]  = w1;
        v.w[2]  = w2;
        v.w[3]  = w3;
        v.unsup = unsup;
        v.uaddr = uaddr;
        return v;
    endfunction

    vec_t vecs[6];

    initial begin
        int w0;
        int d0;

        vecs[0] = mk(11'd2, 0, -1, 32'h20080005, 32'h00000000, 0, 0, 1'b0, 10'd0);
        vecs[1] = mk(11'd2, 3, -1, 32'h20080005, 32'h00000000, 0, 0, 1'b0, 10'd0);
        vecs[2] = mk(11'd4, 1, -1, 32'h8C220004, 32'h3C010000, 32'hAC220008, 32'h08000010, 1'b1, 10'd1);
        vecs[3] = mk(11'd3, 2, -1, 32'hFC000000, 32'h7C000000, 32'h70000000, 0, 1'b1, 10'd0);
        vecs[4] = mk(11'd3, 1, -1, 32'h24000001, 32'h30000000, 32'h10000000, 0, 1'b1, 10'd2);
        vecs[5] = mk(11'd2, 1, 2,  32'h20080005, 32'hA4000123, 0, 0, 1'b0, 10'd0);

        // Reset with Start and ByteValid active: reset wins, outputs all low.
        Rst           = 1'b1;
        bus.Start     = 1'b1;
        bus.Count     = 11'd5;
        bus.ByteValid = 1'b1;
        bus.ByteIn    = 8'hAA;
        repeat (2) @(negedge Clk);
        #1;
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_ready", 32'(bus.ByteReady), 32'd0);
        check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_memdata", bus.MemData, 32'd0);
        check("rst_memaddr", 32'(bus.MemAddr), 32'd0);
        check("rst_unsup", 32'(bus.UnsupOp), 32'd0);
        bus.Start     = 1'b0;
        bus.ByteValid = 1'b0;
        Rst           = 1'b0;
        @(negedge Clk);
        #1;
        check("post_rst_idle_busy", 32'(bus.Busy), 32'd0);
        check("post_rst_idle_ready", 32'(bus.ByteReady), 32'd0);

        // Table-driven load scenarios.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) word_buf[i] = vecs[k].w[i];
            run_load(vecs[k].count, vecs[k].gap, vecs[k].poke, vecs[k].unsup, vecs[k].uaddr);
        end

        // Count = 0: Done on the next cycle, nothing written, not busy.
        w0 = n_writes;
        start_pulse(11'd0);
        check("cnt0_done", 32'(bus.Done), 32'd1);
        check("cnt0_busy", 32'(bus.Busy), 32'd0);
        check("cnt0_memwrite", 32'(bus.MemWrite), 32'd0);
        idle_cycle();
        check("cnt0_done_drop", 32'(bus.Done), 32'd0);
        check("cnt0_writes", 32'(n_writes - w0), 32'd0);

        // Reset part-way through word 1: word 0 stays the only write.
        word_buf[0] = 32'h20080005;
        word_buf[1] = 32'h11223344;
        exp_q.push_back({10'd0, 32'h20080005});
        start_pulse(11'd2);
        for (int b = 0; b < 6; b++) send_byte(word_buf[b / 4][31 - 8*(b % 4) -: 8]);
        Rst = 1'b1;
        #1;
        check("abort_rst_memdata", bus.MemData, 32'd0);
        check("abort_rst_ready", 32'(bus.ByteReady), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        w0 = n_writes;
        check("abort_busy", 32'(bus.Busy), 32'd0);
        check("abort_memwrite", 32'(bus.MemWrite), 32'd0);
        check("abort_memdata_clr", bus.MemData, 32'd0);
        bus.ByteValid = 1'b1;
        repeat (4) @(negedge Clk);
        #1;
        bus.ByteValid = 1'b0;
        check("abort_no_writes", 32'(n_writes - w0), 32'd0);
        check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        word_buf[0] = 32'h2108FFFF;
        word_buf[1] = 32'h8D0A0010;
        run_load(11'd2, 0, -1, 1'b0, 10'd0);

        // Whole memory, then an oversize request that must clamp.
        for (int i = 0; i < 1024; i++) word_buf[i] = {6'b100011, 26'(i * 37 + 5)};
        run_load(11'd1024, 0, -1, 1'b0, 10'd0);
        check("full_last_addr", 32'(last_addr), 32'd1023);
        for (int i = 0; i < 1024; i++) word_buf[i] = {6'b001101, 26'(i ^ 26'h155)};
        word_buf[700] = 32'hFFFF0000;
        run_load(11'd2000, 0, -1, 1'b1, 10'd700);
        check("clamp_last_addr", 32'(last_addr), 32'd1023);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit in case a bounded wait is ever defeated.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter: ADDR_W, default 10, instruction-memory word-address width.
REQ-002 SHALL have port: Clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: Rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: Start  input  1  begin load when idle.
REQ-005 SHALL have port: Count  input  ADDR_W+1  words to load.
REQ-006 SHALL have port: ByteIn  input  8  program byte stream, big-endian within each word.
REQ-007 SHALL have port: ByteValid  input  1  ByteIn valid.
REQ-008 SHALL have port: ByteReady  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port: MemWrite  output  1  instruction-memory write strobe.
REQ-010 SHALL have port: MemAddr  output  ADDR_W  word address.
REQ-011 SHALL have port: MemData  output  32  instruction word.
REQ-012 SHALL have port: Busy  output  1  load in progress; processor held while high.
REQ-013 SHALL have port: Done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port: UnsupOp  output  1  sticky flag, a loaded word has an opcode the datapath controller does not support.
REQ-015 SHALL have port: UnsupAddr  output  ADDR_W  address of the first unsupported word.

Function
REQ-016 SHALL implement states IDLE, LOAD, WRITE, DONE.
REQ-017 In IDLE, ByteReady, MemWrite and Busy SHALL be 0.
REQ-018 In IDLE, Start=1 with Count!=0 SHALL latch Count, set the word index and byte index to 0, clear UnsupOp and UnsupAddr, and enter LOAD.
REQ-019 In IDLE, Start=1 with Count=0 SHALL enter DONE with no memory write.
REQ-020 A Count above 2^ADDR_W SHALL be clamped to 2^ADDR_W.
REQ-021 In LOAD, ByteReady SHALL be 1, and a byte SHALL be accepted only in a cycle where ByteValid and ByteReady are both 1.
REQ-022 Accepted bytes 0..3 of a word SHALL fill bits [31:24], [23:16], [15:8] and [7:0] in that order.
REQ-023 After the 4th accepted byte, the block SHALL enter WRITE in the next cycle.
REQ-024 In WRITE, MemWrite SHALL be 1 for exactly one cycle, with MemAddr equal to the word index and MemData equal to the assembled word.
REQ-025 In WRITE, ByteReady SHALL be 0.
REQ-026 Minimum throughput SHALL be one word per 5 cycles.
REQ-027 In WRITE, if MemData[31:26] is outside the supported set and UnsupOp is 0, the block SHALL set UnsupOp=1 and UnsupAddr to the word index.
REQ-028 Later unsupported words SHALL NOT change UnsupAddr.
REQ-029 The supported opcode set SHALL be: 000000, 001000, 001001, 001010, 001011, 001100, 001101, 001110, 011100, 011111, 100000, 100001, 100011, 101000, 101001, 101011.
REQ-030 Loading SHALL continue after an unsupported word is detected.
REQ-031 After WRITE, the word index SHALL increment; if words written equals the latched Count, the block SHALL enter DONE, otherwise LOAD.
REQ-032 The word index SHALL never wrap, so the final address is Count-1 (1023 at the maximum count).
REQ-033 In DONE, Done SHALL be 1 for one cycle, followed by a return to IDLE.
REQ-034 UnsupOp and UnsupAddr SHALL hold their values until the next accepted Start or Rst.
REQ-035 Busy SHALL be 1 in LOAD and WRITE only.
REQ-036 Start SHALL be ignored outside IDLE.
REQ-037 ByteIn SHALL be ignored when ByteReady is 0.
REQ-038 MemData and MemAddr SHALL hold their last values when MemWrite is 0.

Reset
REQ-039 Rst=1 at a clock edge SHALL force IDLE and clear the word index, byte index, assembled word, MemAddr, MemData, UnsupOp and UnsupAddr to 0.
REQ-040 While Rst=1, all outputs SHALL be 0.
REQ-041 Rst during LOAD or WRITE SHALL abort the load; no MemWrite SHALL occur in the cycle after Rst, and already-written memory SHALL NOT be touched.
REQ-042 Rst SHALL take priority over Start and ByteValid in the same cycle.

Verification
REQ-043 SHALL cover: Rst; Start, Count=2; bytes 20 08 00 05 00 00 00 00 -> writes [0]=0x20080005, [1]=0x00000000; Done pulses once; UnsupOp=0.
REQ-044 SHALL cover: same stream with ByteValid gaps of 0-3 cycles -> identical writes; exactly 2 MemWrite pulses; Busy high until Done.
REQ-045 SHALL cover: Count=4; word 3 = 0x08000010, word 1 = 0x3C010000 -> UnsupOp=1 and UnsupAddr=1; all 4 words written.
REQ-046 SHALL cover: Rst after 2 bytes of word 1 -> IDLE next cycle with no MemWrite and Busy=0; a restart writes from address 0.
REQ-047 SHALL cover: Start with Count=0 -> Done next cycle with no MemWrite; Start pulsed during LOAD -> no effect on the word index.
REQ-048 SHALL cover: Count=1024 -> 1024 writes, last MemAddr=1023, no second write to address 0; Count=2000 clamped to 1024.
